lap_timer: RTL and testbench
============================

# lap_timer

Parametrised successor to the single-mode stopwatch. Keeps an hours:minutes:seconds:centiseconds time value that counts up or down at a prescaled tick rate. Records lap snapshots into a small show-ahead FIFO, supports preset load, and flags expiry on countdown-to-zero or up-count saturation. Sits behind the UART command decoder, which drives its command pulses and reads back time and laps.

## Interface
Parameters:
- CLK_PER_TICK, 100000: clk cycles per centisecond tick; must be ≥ 1.
- MAX_HOURS, 24: hours range 0..MAX_HOURS-1; must be ≤ 64.
- LAPS, 4: lap FIFO depth; must be ≥ 1.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  synchronous, active-high.
- sel  in  2  command gate; start/lap/load are ignored when sel == 2'd3.
- start  in  1  one-cycle pulse; toggles run/stop.
- lap  in  1  one-cycle pulse; snapshots the current time into the FIFO.
- clear  in  1  one-cycle pulse; zeroes everything. Not gated by sel.
- dir  in  1  0 = count up, 1 = count down; sampled at every tick.
- load  in  1  one-cycle pulse; presets time from the load_* inputs.
- load_hours/load_minutes/load_seconds/load_centis  in  6/6/6/7  preset value.
- hours/minutes/seconds  out  6 each  current time.
- centis  out  7  current centiseconds.
- running  out  1  state == RUNNING.
- done  out  1  state == EXPIRED.
- lap_hours/lap_minutes/lap_seconds/lap_centis  out  6/6/6/7  FIFO head; combinational from storage.
- lap_valid  out  1  FIFO not empty.
- lap_rd  in  1  pops the head; ignored when empty.
- lap_count  out  $clog2(LAPS+1)  number of entries in the FIFO.
- lap_overflow  out  1  sticky; set when a lap is dropped because the FIFO is full.

## Operation
- Reset: all outputs 0, state STOPPED, prescaler 0, FIFO empty.
- Command priority, highest first: reset > clear > load > start. lap and lap_rd are independent of that chain.
- clear: time 0, STOPPED, prescaler 0, FIFO emptied, lap_overflow cleared.
- States and transitions:
  - STOPPED: start → RUNNING; load → STOPPED with the preset value.
  - RUNNING: start → STOPPED; load is ignored.
  - EXPIRED: start is ignored; load → STOPPED with the preset value; clear → STOPPED.
- Load validity: load is rejected (no effect at all) if minutes > 59, seconds > 59, centis > 99, or hours ≥ MAX_HOURS. An accepted load also zeroes the prescaler.
- Prescaler: counts only in RUNNING and wraps at CLK_PER_TICK-1. A tick is generated on the wrap. The prescaler holds its value while STOPPED.
- Up tick:
  - centis 99→0 carries into seconds; seconds 59→0 carries into minutes; minutes 59→0 carries into hours.
  - Terminal value is MAX_HOURS-1:59:59.99.
- Down tick: mirror of the up tick with borrows: centis 0→99, seconds 0→59, minutes 0→59. Terminal value is 0:00:00.00.
- Reaching or sitting at the terminal value:
  - A tick whose result equals the terminal value enters EXPIRED on the same edge.
  - A tick taken while already at the terminal value changes no time field and enters EXPIRED.
  - The time never wraps past the terminal value.
- Changing dir mid-run takes effect at the next tick.
- Lap push:
  - Taken when lap=1, sel≠3 and state ≠ STOPPED.
  - Captures the registered time of that cycle, i.e. the pre-tick value.
  - When the FIFO is full the push is dropped and lap_overflow is set, unless lap_rd is asserted in the same cycle. Simultaneous push and pop when full succeeds and the count is unchanged.
- Simultaneous push and pop when empty: the push lands, the pop is ignored, and lap_count becomes 1.

## Timing
- All state changes take effect at the edge where the command is sampled, so outputs update 1 cycle after a command pulse.
- First tick after a start from prescaler 0 occurs CLK_PER_TICK cycles after running rises.
- Lap entry: lap_valid and lap_count reflect a push 1 cycle after the push is sampled. Head data is valid in that same cycle.
- lap_rd advances the head at the edge; the next entry is visible the following cycle.
- Reset mid-run or mid-lap overrides everything on that edge.

## Structure
- Package stopwatch_pkg holds:
  - mode_t enum {STOPPED, RUNNING, EXPIRED};
  - time_t packed struct {hours[5:0], minutes[5:0], seconds[5:0], centis[6:0]};
  - constants MAX_MIN=59, MAX_SEC=59, MAX_CS=99.
- Sub-module lap_fifo:
  - parameter DEPTH; stores time_t entries;
  - ports push, pop, data in, head out, valid, count, full;
  - circular buffer with read/write pointers and a count register.
- Top level holds the prescaler, the time next-state logic (up and down carry chains) and the mode FSM.

## Test plan
Bench parameters: CLK_PER_TICK=2, MAX_HOURS=24, LAPS=2.
- Reset, start, then 200 cycles → time 0:00:01.00; running=1; done=0.
- load 0:00:00.02 with dir=1, then start → after 4 cycles time = 0:00:00.00 and done=1. A further start pulse → still EXPIRED, time unchanged.
- load 23:59:59.98 with dir=0, then start → after 2 cycles 23:59:59.99 and done=1. Time holds at that value for another 10 cycles.
- Three lap pulses while running → lap_count=2 and lap_overflow=1. The head equals the first snapshot. After one lap_rd, the head equals the second snapshot.
- load with minutes=60 → rejected: time unchanged and state unchanged.
- load with sel=3 → ignored. start with sel=3 → ignored.
- clear and start asserted in the same cycle while RUNNING → STOPPED, time 0, FIFO empty, overflow cleared.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and carry-chain helpers for the lap timer.
package stopwatch_pkg;

    localparam int unsigned MAX_MIN = 59;
    localparam int unsigned MAX_SEC = 59;
    localparam int unsigned MAX_CS  = 99;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } mode_t;

    typedef struct packed {
        logic [5:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
        logic [6:0] centis;
    } time_t;

    // One centisecond forward; caller guarantees the value is below the up terminal.
    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.centis != 7'(MAX_CS)) begin
            r.centis = t.centis + 7'd1;
        end else begin
            r.centis = '0;
            if (t.seconds != 6'(MAX_SEC)) begin
                r.seconds = t.seconds + 6'd1;
            end else begin
                r.seconds = '0;
                if (t.minutes != 6'(MAX_MIN)) begin
                    r.minutes = t.minutes + 6'd1;
                end else begin
                    r.minutes = '0;
                    r.hours   = t.hours + 6'd1;
                end
            end
        end
        return r;
    endfunction

    // One centisecond backward; caller guarantees the value is above zero.
    function automatic time_t time_dec(input time_t t);
        time_t r;
        r = t;
        if (t.centis != 7'd0) begin
            r.centis = t.centis - 7'd1;
        end else begin
            r.centis = 7'(MAX_CS);
            if (t.seconds != 6'd0) begin
                r.seconds = t.seconds - 6'd1;
            end else begin
                r.seconds = 6'(MAX_SEC);
                if (t.minutes != 6'd0) begin
                    r.minutes = t.minutes - 6'd1;
                end else begin
                    r.minutes = 6'(MAX_MIN);
                    r.hours   = t.hours - 6'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Show-ahead circular FIFO of lap snapshots; head is read straight from storage.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  time_t                      data_i,
    output time_t                      head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    time_t            mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy next-state; a pop frees the slot a same-cycle push needs.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (clr_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/lap_timer.sv
// Up/down h:m:s.cs timer with prescaled ticks, preset load, expiry and a lap FIFO.
module lap_timer
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK = 100000,
    parameter int unsigned MAX_HOURS    = 24,
    parameter int unsigned LAPS         = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                sel,
    input  logic                      start,
    input  logic                      lap,
    input  logic                      clear,
    input  logic                      dir,
    input  logic                      load,
    input  logic [5:0]                load_hours,
    input  logic [5:0]                load_minutes,
    input  logic [5:0]                load_seconds,
    input  logic [6:0]                load_centis,
    output logic [5:0]                hours,
    output logic [5:0]                minutes,
    output logic [5:0]                seconds,
    output logic [6:0]                centis,
    output logic                      running,
    output logic                      done,
    output logic [5:0]                lap_hours,
    output logic [5:0]                lap_minutes,
    output logic [5:0]                lap_seconds,
    output logic [6:0]                lap_centis,
    output logic                      lap_valid,
    input  logic                      lap_rd,
    output logic [$clog2(LAPS+1)-1:0] lap_count,
    output logic                      lap_overflow
);

    localparam int unsigned PS_W  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int unsigned CNT_W = $clog2(LAPS + 1);
    localparam time_t TIME_MAX = '{
        hours:   6'(MAX_HOURS - 1),
        minutes: 6'(MAX_MIN),
        seconds: 6'(MAX_SEC),
        centis:  7'(MAX_CS)
    };

    mode_t            mode_q, mode_d;
    time_t            time_q, time_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             ovf_q, ovf_d;
    logic             running_q, done_q;

    logic             cmd_ok;
    logic             start_g;
    logic             load_ok;
    time_t            load_val;
    time_t            terminal;
    logic             tick;
    logic             lap_push;
    logic             lap_pop;
    logic             fifo_full;
    time_t            fifo_head;
    logic             fifo_valid;
    logic [CNT_W-1:0] fifo_count;

    // Command gating and preset validation.
    always_comb begin
        cmd_ok   = (sel != 2'd3);
        start_g  = start && cmd_ok;
        load_val = '{hours: load_hours, minutes: load_minutes,
                     seconds: load_seconds, centis: load_centis};
        load_ok  = load && cmd_ok
                   && ({1'b0, load_hours} < 7'(MAX_HOURS))
                   && (load_minutes <= 6'(MAX_MIN))
                   && (load_seconds <= 6'(MAX_SEC))
                   && (load_centis  <= 7'(MAX_CS));
    end

    assign lap_push = lap && cmd_ok && (mode_q != STOPPED) && !clear;
    assign lap_pop  = lap_rd && !clear;

    // Mode FSM, prescaler, time carry/borrow chain and overflow flag.
    always_comb begin
        mode_d   = mode_q;
        time_d   = time_q;
        ps_d     = ps_q;
        ovf_d    = ovf_q;
        tick     = 1'b0;
        terminal = dir ? '0 : TIME_MAX;
        unique case (mode_q)
            RUNNING: begin
                tick = (ps_q == PS_W'(CLK_PER_TICK - 1));
                ps_d = tick ? '0 : ps_q + PS_W'(1);
                if (tick) begin
                    if (time_q != terminal) begin
                        time_d = dir ? time_dec(time_q) : time_inc(time_q);
                    end
                    if (time_d == terminal) begin
                        mode_d = EXPIRED;
                    end
                end
                if (start_g) begin
                    mode_d = STOPPED;
                end
            end
            STOPPED: begin
                if (load_ok) begin
                    time_d = load_val;
                    ps_d   = '0;
                end else if (start_g) begin
                    mode_d = RUNNING;
                end
            end
            EXPIRED: begin
                if (load_ok) begin
                    time_d = load_val;
                    ps_d   = '0;
                    mode_d = STOPPED;
                end
            end
            default: mode_d = STOPPED;
        endcase
        if (lap_push && fifo_full && !lap_rd) begin
            ovf_d = 1'b1;
        end
        if (clear) begin
            mode_d = STOPPED;
            time_d = '0;
            ps_d   = '0;
            ovf_d  = 1'b0;
        end
    end

    // Mode state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= STOPPED;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Time, prescaler and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            time_q    <= '0;
            ps_q      <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            time_q    <= time_d;
            ps_q      <= ps_d;
            ovf_q     <= ovf_d;
            running_q <= (mode_d == RUNNING);
            done_q    <= (mode_d == EXPIRED);
        end
    end

    lap_fifo #(
        .DEPTH (LAPS)
    ) u_lap_fifo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (clear),
        .push_i  (lap_push),
        .pop_i   (lap_pop),
        .data_i  (time_q),
        .head_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count),
        .full_o  (fifo_full)
    );

    assign hours        = time_q.hours;
    assign minutes      = time_q.minutes;
    assign seconds      = time_q.seconds;
    assign centis       = time_q.centis;
    assign running      = running_q;
    assign done         = done_q;
    assign lap_hours    = fifo_head.hours;
    assign lap_minutes  = fifo_head.minutes;
    assign lap_seconds  = fifo_head.seconds;
    assign lap_centis   = fifo_head.centis;
    assign lap_valid    = fifo_valid;
    assign lap_count    = fifo_count;
    assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_lap_timer.sv
// Bench for lap_timer: total-centisecond reference model plus directed literal checks.
module tb_lap_timer;

    localparam int CPT  = 2;
    localparam int MAXH = 24;
    localparam int LAPS = 2;
    localparam int CW   = $clog2(LAPS + 1);
    localparam int MAXT = ((MAXH - 1) * 3600 + 59 * 60 + 59) * 100 + 99;
    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic          clk = 1'b0;
    logic          reset, start, lap, clear, dir, load, lap_rd;
    logic [1:0]    sel;
    logic [5:0]    load_hours, load_minutes, load_seconds;
    logic [6:0]    load_centis;
    logic [5:0]    hours, minutes, seconds, lap_hours, lap_minutes, lap_seconds;
    logic [6:0]    centis, lap_centis;
    logic          running, done, lap_valid, lap_overflow;
    logic [CW-1:0] lap_count;

    lap_timer #(.CLK_PER_TICK(CPT), .MAX_HOURS(MAXH), .LAPS(LAPS)) dut (
        .clk(clk), .reset(reset), .sel(sel), .start(start), .lap(lap),
        .clear(clear), .dir(dir), .load(load),
        .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .load_centis(load_centis),
        .hours(hours), .minutes(minutes), .seconds(seconds), .centis(centis),
        .running(running), .done(done),
        .lap_hours(lap_hours), .lap_minutes(lap_minutes),
        .lap_seconds(lap_seconds), .lap_centis(lap_centis),
        .lap_valid(lap_valid), .lap_rd(lap_rd), .lap_count(lap_count),
        .lap_overflow(lap_overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [24:0] pack_t(input int t);
        return {6'(t / 360000), 6'((t / 6000) % 60), 6'((t / 100) % 60), 7'(t % 100)};
    endfunction

    // Reference model: time as a plain centisecond count, FIFO as a queue.
    int  m_t = 0, m_ps = 0, m_mode = M_STOP;
    int  m_q[$];
    bit  m_ovf = 0;
    bit  seen_reset = 0;

    always @(posedge clk) begin
        bit st, ld, push_req;
        int term;
        if (reset) begin
            m_t = 0; m_ps = 0; m_mode = M_STOP; m_q.delete(); m_ovf = 0; seen_reset = 1;
        end else if (clear) begin
            m_t = 0; m_ps = 0; m_mode = M_STOP; m_q.delete(); m_ovf = 0;
        end else begin
            st = start && sel != 2'd3;
            ld = load && sel != 2'd3 && load_hours < MAXH && load_minutes < 60
                 && load_seconds < 60 && load_centis < 100;
            push_req = lap && sel != 2'd3 && m_mode != M_STOP;
            if (lap_rd && m_q.size() > 0) void'(m_q.pop_front());
            if (push_req) begin
                if (m_q.size() < LAPS) m_q.push_back(m_t);
                else m_ovf = 1;
            end
            if (m_mode == M_RUN) begin
                if (m_ps == CPT - 1) begin
                    m_ps = 0;
                    term = dir ? 0 : MAXT;
                    if (m_t != term) m_t = dir ? m_t - 1 : m_t + 1;
                    if (m_t == term) m_mode = M_EXP;
                end else begin
                    m_ps++;
                end
                if (st) m_mode = M_STOP;
            end else if (ld) begin
                m_t = ((load_hours * 60 + load_minutes) * 60 + load_seconds) * 100 + load_centis;
                m_ps = 0;
                m_mode = M_STOP;
            end else if (st && m_mode == M_STOP) begin
                m_mode = M_RUN;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (seen_reset) begin
            chk("model_time", {hours, minutes, seconds, centis}, pack_t(m_t));
            chk("model_flags", {running, done, lap_valid, lap_overflow, lap_count},
                {m_mode == M_RUN, m_mode == M_EXP, m_q.size() > 0, m_ovf, CW'(m_q.size())});
            if (m_q.size() > 0)
                chk("model_head", {lap_hours, lap_minutes, lap_seconds, lap_centis}, pack_t(m_q[0]));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [1:0] s);
        sel = s; start = 1'b1; idle(1); start = 1'b0; sel = 2'd0;
    endtask

    task automatic pulse_lap(input logic rd);
        lap = 1'b1; lap_rd = rd; idle(1); lap = 1'b0; lap_rd = 1'b0;
    endtask

    task automatic pulse_rd();
        lap_rd = 1'b1; idle(1); lap_rd = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] s, input int h, input int m, input int sc, input int c);
        sel = s; load = 1'b1;
        load_hours = 6'(h); load_minutes = 6'(m); load_seconds = 6'(sc); load_centis = 7'(c);
        idle(1);
        load = 1'b0; sel = 2'd0;
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s, input int c);
        chk(name, {hours, minutes, seconds, centis}, {6'(h), 6'(m), 6'(s), 7'(c)});
    endtask

    initial begin
        int bad [3][4];
        bad[0] = '{1, 60, 3, 4};
        bad[1] = '{24, 0, 0, 0};
        bad[2] = '{1, 2, 3, 100};

        reset = 1'b1; start = 0; lap = 0; clear = 0; dir = 0; load = 0; lap_rd = 0;
        sel = 2'd0; load_hours = 0; load_minutes = 0; load_seconds = 0; load_centis = 0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk_time("reset_time", 0, 0, 0, 0);
        chk("reset_flags", {running, done, lap_valid, lap_overflow, lap_count}, 0);

        // Count up one second.
        pulse_start(2'd0);
        idle(200);
        @(negedge clk);
        chk_time("up_1s_time", 0, 0, 1, 0);
        chk("up_1s_flags", {running, done}, 2'b10);

        // Countdown to zero.
        pulse_start(2'd0);
        dir = 1'b1;
        do_load(2'd0, 0, 0, 0, 2);
        @(negedge clk);
        chk_time("load_002", 0, 0, 0, 2);
        pulse_start(2'd0);
        idle(4);
        @(negedge clk);
        chk_time("down_zero_time", 0, 0, 0, 0);
        chk("down_zero_flags", {running, done}, 2'b01);
        pulse_start(2'd0);
        idle(2);
        @(negedge clk);
        chk("expired_start_ignored", {running, done, hours, minutes, seconds, centis}, 27'h1 << 25);

        // Up-count saturation.
        dir = 1'b0;
        do_load(2'd0, 23, 59, 59, 98);
        pulse_start(2'd0);
        idle(2);
        @(negedge clk);
        chk_time("sat_time", 23, 59, 59, 99);
        chk("sat_done", done, 1);
        idle(10);
        @(negedge clk);
        chk_time("sat_hold_time", 23, 59, 59, 99);

        // Laps with overflow.
        do_load(2'd0, 0, 0, 0, 0);
        pulse_start(2'd0);
        idle(10);
        pulse_lap(1'b0);
        idle(1);
        pulse_lap(1'b0);
        idle(1);
        pulse_lap(1'b0);
        @(negedge clk);
        chk("lap_full", {lap_valid, lap_overflow, lap_count}, {1'b1, 1'b1, CW'(2)});
        chk("lap_head0", {lap_hours, lap_minutes, lap_seconds, lap_centis}, {6'd0, 6'd0, 6'd0, 7'd5});
        pulse_rd();
        @(negedge clk);
        chk("lap_head1", {lap_hours, lap_minutes, lap_seconds, lap_centis}, {6'd0, 6'd0, 6'd0, 7'd6});
        chk("lap_count1", lap_count, 1);

        // Load validation and sel gating while stopped.
        pulse_start(2'd0);
        do_load(2'd0, 1, 2, 3, 4);
        @(negedge clk);
        chk_time("load_ok", 1, 2, 3, 4);
        for (int i = 0; i < 3; i++) begin
            do_load(2'd0, bad[i][0], bad[i][1], bad[i][2], bad[i][3]);
            @(negedge clk);
            chk_time("load_reject", 1, 2, 3, 4);
            chk("load_reject_state", {running, done}, 2'b00);
        end
        do_load(2'd3, 5, 0, 0, 0);
        @(negedge clk);
        chk_time("load_sel3", 1, 2, 3, 4);
        pulse_start(2'd3);
        idle(1);
        @(negedge clk);
        chk("start_sel3", running, 0);
        pulse_lap(1'b0);
        @(negedge clk);
        chk("lap_stopped_ignored", lap_count, 1);

        // clear and start together while running.
        pulse_start(2'd0);
        pulse_lap(1'b0);
        clear = 1'b1; start = 1'b1;
        idle(1);
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_time("clear_time", 0, 0, 0, 0);
        chk("clear_flags", {running, done, lap_valid, lap_overflow, lap_count}, 0);

        // Push and pop together on an empty FIFO.
        pulse_start(2'd0);
        idle(1);
        pulse_lap(1'b1);
        @(negedge clk);
        chk("empty_push_pop", {lap_valid, lap_count}, {1'b1, CW'(1)});
        chk("empty_push_pop_head", {lap_hours, lap_minutes, lap_seconds, lap_centis}, 25'd0);

        // Reset mid-run.
        idle(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clk);
        chk_time("midrun_reset_time", 0, 0, 0, 0);
        chk("midrun_reset_flags", {running, done, lap_valid, lap_overflow, lap_count}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
